// File: rtl/axi4_arb_pkg.sv
// Shared AXI4 widths and response encodings for the two-requester read arbiter.
package axi4_arb_pkg;
  localparam int ID_W   = 5;
  localparam int SID_W  = ID_W + 1;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;
endpackage

// File: rtl/axi4_outstanding_counter.sv
// Per-requester count of open read bursts; simultaneous inc/dec leaves it unchanged,
// and a decrement at zero is ignored.
module axi4_outstanding_counter #(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc && !empty) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axi4_read_arbiter.sv
// Round-robin merge of two AXI4 read requesters onto one downstream port; AR is
// registered (1 cycle), R is routed back combinationally by ID bit 5.
module axi4_read_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  input  logic [ID_W-1:0]   m0_ar_id,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [ID_W-1:0]   m0_r_id,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,
  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  input  logic [ID_W-1:0]   m1_ar_id,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [ID_W-1:0]   m1_r_id,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,
  output logic              s_ar_valid,
  input  logic              s_ar_ready,
  output logic [ADDR_W-1:0] s_ar_addr,
  output logic [SID_W-1:0]  s_ar_id,
  input  logic              s_r_valid,
  output logic              s_r_ready,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [SID_W-1:0]  s_r_id,
  input  logic [1:0]        s_r_resp,
  input  logic              s_r_last
);
  logic [1:0]        full, empty, elig, gnt, ar_hs, r_dec;
  logic              load, r_last_hs;
  logic              ar_vld_q, ar_vld_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [SID_W-1:0]  ar_id_q, ar_id_d;
  logic              last_q, last_d;  // 1: M1 was granted most recently

  assign elig = {m1_ar_valid & ~full[1], m0_ar_valid & ~full[0]};

  always_comb begin
    gnt = elig;
    if (&elig) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  assign load        = ~ar_vld_q | s_ar_ready;
  // Gating with reset drops ready the moment reset rises, before any edge.
  assign ar_hs       = reset ? 2'b00 : (gnt & {2{load}});
  assign m0_ar_ready = ar_hs[0];
  assign m1_ar_ready = ar_hs[1];

  always_comb begin
    ar_vld_d  = ar_vld_q;
    ar_addr_d = ar_addr_q;
    ar_id_d   = ar_id_q;
    last_d    = last_q;
    if (load) begin
      ar_vld_d = |ar_hs;
    end
    if (ar_hs[0]) begin
      ar_addr_d = m0_ar_addr;
      ar_id_d   = {1'b0, m0_ar_id};
      last_d    = 1'b0;
    end else if (ar_hs[1]) begin
      ar_addr_d = m1_ar_addr;
      ar_id_d   = {1'b1, m1_ar_id};
      last_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar_vld_q  <= 1'b0;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      last_q    <= 1'b1;
    end else begin
      ar_vld_q  <= ar_vld_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q   <= ar_id_d;
      last_q    <= last_d;
    end
  end

  assign s_ar_valid = ar_vld_q;
  assign s_ar_addr  = ar_addr_q;
  assign s_ar_id    = ar_id_q;

  assign m0_r_valid = s_r_valid & ~s_r_id[SID_W-1];
  assign m1_r_valid = s_r_valid &  s_r_id[SID_W-1];
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_id    = s_r_id[ID_W-1:0];
  assign m1_r_id    = s_r_id[ID_W-1:0];
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;
  assign s_r_ready  = s_r_id[SID_W-1] ? m1_r_ready : m0_r_ready;

  assign r_last_hs = s_r_valid & s_r_ready & s_r_last;
  assign r_dec     = {r_last_hs & s_r_id[SID_W-1], r_last_hs & ~s_r_id[SID_W-1]};

  axi4_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt0 (
    .clock(clock), .reset(reset), .inc(ar_hs[0]), .dec(r_dec[0]),
    .full(full[0]), .empty(empty[0])
  );

  axi4_outstanding_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_cnt1 (
    .clock(clock), .reset(reset), .inc(ar_hs[1]), .dec(r_dec[1]),
    .full(full[1]), .empty(empty[1])
  );

  // A last beat for a requester with nothing open is dropped; flag it.
  a_no_dec_on_empty: assert property (@(posedge clock) disable iff (reset)
    (r_dec & empty) == 2'b00);
endmodule

// File: tb/tb_axi4_read_arbiter.sv
// Directed bench: R-routing vector table plus hand sequences for arbitration,
// AR stall, outstanding limit, same-cycle inc/dec and asynchronous reset.
module tb_axi4_read_arbiter;
  logic        clock;
  logic        reset;
  logic        m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [31:0] m0_ar_addr, m1_ar_addr;
  logic [4:0]  m0_ar_id, m1_ar_id;
  logic        m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
  logic [31:0] m0_r_data, m1_r_data;
  logic [4:0]  m0_r_id, m1_r_id;
  logic [1:0]  m0_r_resp, m1_r_resp;
  logic        s_ar_valid, s_ar_ready;
  logic [31:0] s_ar_addr;
  logic [5:0]  s_ar_id;
  logic        s_r_valid, s_r_ready, s_r_last;
  logic [31:0] s_r_data;
  logic [5:0]  s_r_id;
  logic [1:0]  s_r_resp;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_read_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clock(clock), .reset(reset),
    .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr), .m0_ar_id(m0_ar_id),
    .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data), .m0_r_id(m0_r_id),
    .m0_r_resp(m0_r_resp), .m0_r_last(m0_r_last),
    .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr), .m1_ar_id(m1_ar_id),
    .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data), .m1_r_id(m1_r_id),
    .m1_r_resp(m1_r_resp), .m1_r_last(m1_r_last),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [5:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        r0;
    logic        r1;
    logic        e_v0;
    logic        e_v1;
    logic [4:0]  e_id;
    logic        e_srdy;
  } rvec_t;

  rvec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m0_ar_valid = 0; m0_ar_addr = 0; m0_ar_id = 0; m0_r_ready = 0;
    m1_ar_valid = 0; m1_ar_addr = 0; m1_ar_id = 0; m1_r_ready = 0;
    s_ar_ready = 0; s_r_valid = 0; s_r_data = 0; s_r_id = 0; s_r_resp = 0; s_r_last = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  initial begin
    //           vld id     data          resp  last r0 r1 v0 v1 id     srdy
    tbl[0] = '{1'b1, 6'h25, 32'hDEADBEEF, 2'd0, 1'b1, 0, 1, 0, 1, 5'h05, 1};
    tbl[1] = '{1'b1, 6'h25, 32'hDEADBEEF, 2'd0, 1'b1, 1, 0, 0, 1, 5'h05, 0};
    tbl[2] = '{1'b1, 6'h03, 32'h12345678, 2'd2, 1'b0, 1, 0, 1, 0, 5'h03, 1};
    tbl[3] = '{1'b1, 6'h03, 32'h12345678, 2'd2, 1'b0, 0, 1, 1, 0, 5'h03, 0};
    tbl[4] = '{1'b0, 6'h3F, 32'h0000A5A5, 2'd3, 1'b1, 0, 1, 0, 0, 5'h1F, 1};
    tbl[5] = '{1'b1, 6'h1F, 32'hCAFEF00D, 2'd1, 1'b1, 1, 1, 1, 0, 5'h1F, 1};

    // Reset state, with a requester asking the whole time
    reset = 1;
    idle_inputs();
    m0_ar_valid = 1;
    tick();
    settle();
    check("rst_s_ar_valid", s_ar_valid, 0);
    check("rst_m0_ar_ready", m0_ar_ready, 0);
    check("rst_cnt0", dut.u_cnt0.cnt_q, 0);
    check("rst_cnt1", dut.u_cnt1.cnt_q, 0);
    m0_ar_valid = 0;

    // R routing is combinational and works while reset is held
    for (int i = 0; i < 6; i++) begin
      s_r_valid = tbl[i].vld; s_r_id = tbl[i].id; s_r_data = tbl[i].data;
      s_r_resp = tbl[i].resp; s_r_last = tbl[i].last;
      m0_r_ready = tbl[i].r0; m1_r_ready = tbl[i].r1;
      settle();
      check($sformatf("r_m0_valid[%0d]", i), m0_r_valid, tbl[i].e_v0);
      check($sformatf("r_m1_valid[%0d]", i), m1_r_valid, tbl[i].e_v1);
      check($sformatf("r_m0_id[%0d]", i), m0_r_id, tbl[i].e_id);
      check($sformatf("r_m1_id[%0d]", i), m1_r_id, tbl[i].e_id);
      check($sformatf("r_m0_data[%0d]", i), m0_r_data, tbl[i].data);
      check($sformatf("r_m1_data[%0d]", i), m1_r_data, tbl[i].data);
      check($sformatf("r_resp[%0d]", i), m1_r_resp, tbl[i].resp);
      check($sformatf("r_last[%0d]", i), m0_r_last, tbl[i].last);
      check($sformatf("r_s_ready[%0d]", i), s_r_ready, tbl[i].e_srdy);
    end

    // Both requesting every cycle: M0, M1, M0, M1
    do_reset();
    m0_ar_valid = 1; m0_ar_id = 5'h01; m0_ar_addr = 32'h100;
    m1_ar_valid = 1; m1_ar_id = 5'h02; m1_ar_addr = 32'h200;
    s_ar_ready = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("rr_m0_ready[%0d]", k), m0_ar_ready, (k % 2 == 0));
      check($sformatf("rr_m1_ready[%0d]", k), m1_ar_ready, (k % 2 == 1));
      if (k > 0) begin
        check($sformatf("rr_s_ar_valid[%0d]", k), s_ar_valid, 1);
        check($sformatf("rr_s_ar_id[%0d]", k), s_ar_id, (k % 2 == 1) ? 6'h01 : 6'h22);
      end
      tick();
    end
    m0_ar_valid = 0; m1_ar_valid = 0;
    settle();
    check("rr_last_id", s_ar_id, 6'h22);
    check("rr_last_addr", s_ar_addr, 32'h200);
    check("rr_cnt0", dut.u_cnt0.cnt_q, 2);
    check("rr_cnt1", dut.u_cnt1.cnt_q, 2);

    // Downstream stall holds the AR register stable
    do_reset();
    m0_ar_valid = 1; m0_ar_addr = 32'h1000; m0_ar_id = 5'h03;
    settle();
    check("stall_m0_accept", m0_ar_ready, 1);
    check("stall_pre_valid", s_ar_valid, 0);
    tick();
    m0_ar_valid = 0;
    m1_ar_valid = 1; m1_ar_addr = 32'h2000; m1_ar_id = 5'h07;
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("stall_valid[%0d]", k), s_ar_valid, 1);
      check($sformatf("stall_addr[%0d]", k), s_ar_addr, 32'h1000);
      check($sformatf("stall_id[%0d]", k), s_ar_id, 6'h03);
      check($sformatf("stall_m1_ready[%0d]", k), m1_ar_ready, 0);
      tick();
    end
    s_ar_ready = 1;
    settle();
    check("stall_release_m1", m1_ar_ready, 1);
    tick();
    m1_ar_valid = 0;
    settle();
    check("stall_next_id", s_ar_id, 6'h27);
    check("stall_next_addr", s_ar_addr, 32'h2000);

    // Outstanding limit on M1, then release by a last beat
    do_reset();
    s_ar_ready = 1;
    m1_ar_valid = 1; m1_ar_id = 5'h09; m1_ar_addr = 32'h4000;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("lim_m1_ready[%0d]", k), m1_ar_ready, 1);
      tick();
    end
    settle();
    check("lim_5th_blocked", m1_ar_ready, 0);
    check("lim_cnt1_full", dut.u_cnt1.cnt_q, 4);
    tick();
    settle();
    check("lim_6th_blocked", m1_ar_ready, 0);
    s_r_valid = 1; s_r_id = 6'h20; s_r_last = 1; s_r_data = 32'h11; m1_r_ready = 1;
    settle();
    check("lim_r_ready", s_r_ready, 1);
    check("lim_still_blocked", m1_ar_ready, 0);
    tick();
    s_r_valid = 0;
    settle();
    check("lim_cnt1_after_r", dut.u_cnt1.cnt_q, 3);
    check("lim_reaccept", m1_ar_ready, 1);

    // AR handshake and last beat to the same requester in one cycle
    s_r_valid = 1;
    settle();
    check("incdec_ar_ready", m1_ar_ready, 1);
    check("incdec_r_ready", s_r_ready, 1);
    tick();
    s_r_valid = 0; m1_ar_valid = 0;
    settle();
    check("incdec_cnt1", dut.u_cnt1.cnt_q, 3);

    // Asynchronous reset mid-cycle with an AR held downstream
    do_reset();
    m0_ar_valid = 1; m0_ar_addr = 32'h3000; m0_ar_id = 5'h04;
    tick();
    settle();
    check("arst_pre_valid", s_ar_valid, 1);
    check("arst_pre_cnt0", dut.u_cnt0.cnt_q, 1);
    s_ar_ready = 1;
    settle();
    check("arst_pre_ready", m0_ar_ready, 1);
    reset = 1;
    settle();
    check("arst_s_ar_valid", s_ar_valid, 0);
    check("arst_cnt0", dut.u_cnt0.cnt_q, 0);
    check("arst_m0_ready", m0_ar_ready, 0);
    check("arst_m1_ready", m1_ar_ready, 0);
    idle_inputs();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4_read_arbiter.md
AXI4_READ_ARBITER -- requirements
Module: axi4_read_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of open read bursts per requester (range 1..15).
REQ-002 SHALL have port clock, input, 1, the single clock for all logic.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port mN_ar_valid (N=0,1), input, 1, requester N read-address valid.
REQ-005 SHALL have port mN_ar_ready, output, 1, requester N read-address ready.
REQ-006 SHALL have port mN_ar_addr, input, 32, requester N read address.
REQ-007 SHALL have port mN_ar_id, input, 5, requester N transaction ID.
REQ-008 SHALL have port mN_r_valid, output, 1, read data valid to requester N.
REQ-009 SHALL have port mN_r_ready, input, 1, requester N read data ready.
REQ-010 SHALL have ports mN_r_data, mN_r_id, mN_r_resp and mN_r_last, outputs, widths 32, 5, 2 and 1, carrying the read payload to requester N.
REQ-011 SHALL have ports s_ar_valid (output, 1), s_ar_ready (input, 1), s_ar_addr (output, 32) and s_ar_id (output, 6), the shared downstream AR channel.
REQ-012 SHALL have ports s_r_valid (input, 1), s_r_ready (output, 1), s_r_data (input, 32), s_r_id (input, 6), s_r_resp (input, 2) and s_r_last (input, 1), the shared downstream R channel.

Function
REQ-013 SHALL drive s_ar_valid, s_ar_addr and s_ar_id from one holding register; its load condition is "register empty, or s_ar_valid and s_ar_ready in the same cycle".
REQ-014 SHALL give exactly 1 cycle of AR latency: an mN AR handshake in cycle T produces s_ar_valid in cycle T+1.
REQ-015 SHALL form s_ar_id as {N, mN_ar_id}, so bit 5 identifies the source requester.
REQ-016 SHALL treat requester N as eligible when mN_ar_valid is 1 and cnt[N] < MAX_OUTSTANDING.
REQ-017 SHALL arbitrate round-robin: when only one requester is eligible, it is granted; when both are eligible, the requester not granted last is granted.
REQ-018 SHALL update the last-grant pointer only on an AR handshake.
REQ-019 SHALL drive mN_ar_ready = granted(N) AND load condition; at most one mN_ar_ready is 1 per cycle.
REQ-020 SHALL never change s_ar_addr or s_ar_id while s_ar_valid is 1 and s_ar_ready is 0.
REQ-021 SHALL increment cnt[N] on an mN AR handshake.
REQ-022 SHALL decrement cnt[N] on an s_r handshake with s_r_last = 1 and s_r_id[5] = N.
REQ-023 SHALL leave cnt[N] unchanged when its increment and decrement occur in the same cycle.
REQ-024 SHALL hold mN_ar_ready at 0 while cnt[N] = MAX_OUTSTANDING, even if requester N holds the grant.
REQ-025 SHALL route the R channel combinationally (0 latency): mN_r_valid = s_r_valid AND (s_r_id[5] == N); mN_r_data/resp/last = s_r_data/resp/last; mN_r_id = s_r_id[4:0].
REQ-026 SHALL drive s_r_ready = m0_r_ready when s_r_id[5] = 0, else m1_r_ready.
REQ-027 SHALL drop without error an s_r beat whose target count is already 0; an assertion SHALL flag this case in simulation.

Reset
REQ-028 SHALL, while reset is 1, force s_ar_valid = 0, cnt[0] = cnt[1] = 0, and set the last-grant pointer so that M0 wins the first contention.
REQ-029 SHALL return both mN_ar_ready outputs to 0 immediately on assertion of reset; any in-flight AR held in the register is discarded.
REQ-030 SHALL keep the R path combinational during reset, with no registered state involved.

Structure
REQ-031 SHALL place the ID width (5), source-tagged ID width (6), data width (32) and the AXI RESP encodings (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) in a shared package, axi4_arb_pkg.
REQ-032 SHALL instantiate one sub-module, axi4_outstanding_counter, once per requester (inc, dec, full, empty), with width clog2(MAX_OUTSTANDING+1).

Verification
REQ-033 SHALL cover: both requesters valid every cycle with s_ar_ready=1 -> grants alternate M0, M1, M0, M1, with M0 first after reset.
REQ-034 SHALL cover: m0 AR addr=0x1000 id=3 issued while s_ar_ready=0 for 5 cycles -> s_ar_valid held with addr=0x1000 and id=0x03 stable, m1 not accepted.
REQ-035 SHALL cover: 4 m1 ARs with no R returned -> m1_ar_ready=0 on the 5th; one s_r beat with last=1 and id=0x20 -> m1 accepted again the next cycle.
REQ-036 SHALL cover: s_r_id=0x25 with data 0xDEADBEEF -> m1_r_valid=1, m1_r_id=5, m0_r_valid=0, and s_r_ready follows m1_r_ready.
REQ-037 SHALL cover: an AR handshake and a last-beat R to the same requester in one cycle -> count unchanged.
REQ-038 SHALL cover: reset asserted mid-burst with s_ar_valid=1 -> s_ar_valid=0 and counts=0 in the same cycle.
